// File: rtl/keypad_encoder.sv
// Row-scanning encoder for a 4x5 active-low keypad: one key at a time is
// debounced and reported as a single-cycle registered keystroke.

typedef enum logic [3:0] {
    NONE   = 4'd0,
    NUMBER = 4'd1,
    PLUS   = 4'd2,
    MINUS  = 4'd3,
    NEGATE = 4'd4,
    LP     = 4'd5,
    RP     = 4'd6,
    EQUALS = 4'd7,
    CLEAR  = 4'd8
} key_op_t;

typedef struct packed {
    key_op_t    op;
    logic [3:0] num;
} keyStroke_t;

module keypad_encoder #(
    parameter int SCAN_DWELL      = 4,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_b,
    input  logic [4:0] col_n,
    output logic [3:0] row_n,
    output keyStroke_t keyIn
);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, EMIT, RELEASE} state_t;

    localparam logic [3:0] DWELL_LAST = 4'(SCAN_DWELL - 1);
    localparam logic [7:0] DEB_TARGET = 8'(DEBOUNCE_CYCLES);
    localparam keyStroke_t KEY_IDLE   = '{op: NONE, num: 4'd0};

    state_t     state;
    logic [1:0] row;
    logic [3:0] dwell_cnt;
    logic [7:0] deb_cnt;
    logic [4:0] sync_q1;
    logic [4:0] sync_q2;
    logic [4:0] cap_pattern;
    logic [2:0] cap_col;
    logic       single_low;
    logic [2:0] hit_col;

    function automatic logic [3:0] row_drive(input logic [1:0] r);
        return ~(4'b0001 << r);
    endfunction

    function automatic keyStroke_t map_key(input logic [1:0] r, input logic [2:0] c);
        keyStroke_t k;
        k = KEY_IDLE;
        case ({r, c})
            5'b00_000: k = '{NUMBER, 4'd1};
            5'b00_001: k = '{NUMBER, 4'd2};
            5'b00_010: k = '{NUMBER, 4'd3};
            5'b00_011: k = '{PLUS,   4'd0};
            5'b00_100: k = '{MINUS,  4'd0};
            5'b01_000: k = '{NUMBER, 4'd4};
            5'b01_001: k = '{NUMBER, 4'd5};
            5'b01_010: k = '{NUMBER, 4'd6};
            5'b01_011: k = '{LP,     4'd0};
            5'b01_100: k = '{RP,     4'd0};
            5'b10_000: k = '{NUMBER, 4'd7};
            5'b10_001: k = '{NUMBER, 4'd8};
            5'b10_010: k = '{NUMBER, 4'd9};
            5'b10_011: k = '{NEGATE, 4'd0};
            5'b10_100: k = '{CLEAR,  4'd0};
            5'b11_000: k = '{NUMBER, 4'd0};
            5'b11_001: k = '{EQUALS, 4'd0};
            default:   k = KEY_IDLE;
        endcase
        return k;
    endfunction

    // A scan hit needs exactly one column low; anything else is treated as no key.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs; otherwise a latch is inferred.
        single_low = 1'b1;
        hit_col    = 3'd0;
        case (sync_q2)
            5'b11110: hit_col = 3'd0;
            5'b11101: hit_col = 3'd1;
            5'b11011: hit_col = 3'd2;
            5'b10111: hit_col = 3'd3;
            5'b01111: hit_col = 3'd4;
            default:  single_low = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            // NOTE: non-blocking assignments throughout, so every flop sees pre-edge values.
            state     <= SCAN;
            row       <= 2'd0;
            row_n     <= 4'b1110;
            dwell_cnt <= '0;
            deb_cnt   <= '0;
            sync_q1   <= '1;
            sync_q2   <= '1;
            keyIn     <= KEY_IDLE;
            // NOTE: cap_pattern/cap_col are left out of reset; they are written before any read.
        end else begin
            sync_q1 <= col_n;
            sync_q2 <= sync_q1;
            keyIn   <= KEY_IDLE;

            unique case (state)
                SCAN: begin
                    if (dwell_cnt == DWELL_LAST) begin
                        dwell_cnt <= '0;
                        if (single_low) begin
                            cap_pattern <= sync_q2;
                            cap_col     <= hit_col;
                            deb_cnt     <= 8'd1;
                            if (DEB_TARGET == 8'd1) begin
                                state <= EMIT;
                                keyIn <= map_key(row, hit_col);
                            end else begin
                                state <= DEBOUNCE;
                            end
                        end else begin
                            row   <= row + 2'd1;
                            row_n <= row_drive(row + 2'd1);
                        end
                    end else begin
                        dwell_cnt <= dwell_cnt + 4'd1;
                    end
                end

                DEBOUNCE: begin
                    if (sync_q2 == cap_pattern) begin
                        if (deb_cnt + 8'd1 == DEB_TARGET) begin
                            state   <= EMIT;
                            deb_cnt <= '0;
                            keyIn   <= map_key(row, cap_col);
                        end else begin
                            deb_cnt <= deb_cnt + 8'd1;
                        end
                    end else begin
                        state   <= SCAN;
                        deb_cnt <= '0;
                        row     <= row + 2'd1;
                        row_n   <= row_drive(row + 2'd1);
                    end
                end

                EMIT: begin
                    state   <= RELEASE;
                    deb_cnt <= '0;
                end

                // The row stays driven until every column has read high long enough.
                RELEASE: begin
                    if (sync_q2 != 5'b11111) begin
                        deb_cnt <= '0;
                    end else if (deb_cnt + 8'd1 == DEB_TARGET) begin
                        state     <= SCAN;
                        deb_cnt   <= '0;
                        dwell_cnt <= '0;
                        row       <= row + 2'd1;
                        row_n     <= row_drive(row + 2'd1);
                    end else begin
                        deb_cnt <= deb_cnt + 8'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_encoder.sv
// Bench for keypad_encoder: a behavioural keypad drives two instances (default
// and fastest settings); emitted keystrokes are compared against a key-map model.

module tb_keypad_encoder;

    localparam logic [3:0] OP_NUMBER = 4'd1;
    localparam logic [3:0] OP_PLUS   = 4'd2;
    localparam logic [3:0] OP_MINUS  = 4'd3;
    localparam logic [3:0] OP_NEGATE = 4'd4;
    localparam logic [3:0] OP_LP     = 4'd5;
    localparam logic [3:0] OP_RP     = 4'd6;
    localparam logic [3:0] OP_EQUALS = 4'd7;
    localparam logic [3:0] OP_CLEAR  = 4'd8;

    logic       clk = 1'b0;
    logic       rst_b;
    logic [4:0] col_n, col_n_f;
    logic [3:0] row_n, row_n_f;
    logic [7:0] key_in, key_in_f;
    logic [4:0] pressed [4];

    int         checks = 0;
    int         errors = 0;
    int         row_bad = 0;
    logic [7:0] got[$];
    logic [7:0] got_f[$];

    always #5 clk = ~clk;

    keypad_encoder dut (
        .clk   (clk),
        .rst_b (rst_b),
        .col_n (col_n),
        .row_n (row_n),
        .keyIn (key_in)
    );

    keypad_encoder #(.SCAN_DWELL(3), .DEBOUNCE_CYCLES(1)) dut_f (
        .clk   (clk),
        .rst_b (rst_b),
        .col_n (col_n_f),
        .row_n (row_n_f),
        .keyIn (key_in_f)
    );

    // A pressed key shorts its row to its column; each DUT sees only its driven row.
    always_comb begin
        col_n   = 5'b11111;
        col_n_f = 5'b11111;
        for (int r = 0; r < 4; r++) begin
            if (!row_n[r])   col_n   = col_n   & ~pressed[r];
            if (!row_n_f[r]) col_n_f = col_n_f & ~pressed[r];
        end
    end

    function automatic bit onehot_low(input logic [3:0] v);
        return $countones(~v) == 1;
    endfunction

    always @(negedge clk) begin
        if (rst_b === 1'b1) begin
            if (key_in   !== 8'h00) got.push_back(key_in);
            if (key_in_f !== 8'h00) got_f.push_back(key_in_f);
            if (!onehot_low(row_n) || !onehot_low(row_n_f)) row_bad++;
        end
    end

    function automatic logic [7:0] model_key(input int r, input int c);
        logic [7:0] k;
        k = 8'h00;
        if (r < 3 && c < 3)       k = {OP_NUMBER, 4'(3 * r + c + 1)};
        else if (r == 3 && c == 0) k = {OP_NUMBER, 4'd0};
        else if (r == 3 && c == 1) k = {OP_EQUALS, 4'd0};
        else if (r < 3 && c == 3)  k = {(r == 0) ? OP_PLUS  : (r == 1) ? OP_LP : OP_NEGATE, 4'd0};
        else if (r < 3 && c == 4)  k = {(r == 0) ? OP_MINUS : (r == 1) ? OP_RP : OP_CLEAR,  4'd0};
        return k;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_seq(input string tag, input logic [7:0] exp_q[$], input logic [7:0] act_q[$]);
        check({tag, " count"}, act_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("%s[%0d]", tag, i),
                  (i < act_q.size()) ? 32'(act_q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic release_all();
        for (int r = 0; r < 4; r++) pressed[r] = 5'b00000;
    endtask

    task automatic wait_row(input logic [3:0] drive, input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (row_n === drive) found = 1'b1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit         found;
        logic [7:0] exp_q[$];
        logic [3:0] seen;
        int         seq_r[9] = '{2, 0, 1, 1, 0, 0, 1, 3, 2};
        int         seq_c[9] = '{1, 4, 3, 0, 3, 0, 4, 1, 4};
        int         r, c, hold, gap;

        rst_b = 1'b0;
        release_all();
        tick(3);
        check("reset row_n", row_n, 4'b1110);
        check("reset keyIn", key_in, 8'h00);
        rst_b = 1'b1;
        tick(1);
        check("row0 after reset", row_n, 4'b1110);

        // Single press of "8", then release returns to scanning row 3.
        got.delete();
        pressed[2][1] = 1'b1;
        tick(60);
        check("row held for 8", row_n, 4'b1011);
        release_all();
        wait_row(4'b0111, 40, found);
        check("rescan row3 after release", found, 1);
        exp_q.delete(); exp_q.push_back(model_key(2, 1));
        check_seq("key 8", exp_q, got);

        // Bouncing PLUS contact.
        tick(20);
        got.delete();
        for (int i = 0; i < 10; i++) begin
            pressed[0][3] = ~pressed[0][3];
            tick(1);
        end
        check("no emit while bouncing", got.size(), 0);
        pressed[0][3] = 1'b1;
        tick(60);
        release_all();
        tick(30);
        exp_q.delete(); exp_q.push_back(model_key(0, 3));
        check_seq("bounce PLUS", exp_q, got);

        // Key sequence with full releases.
        got.delete();
        exp_q.delete();
        for (int i = 0; i < 9; i++) begin
            pressed[seq_r[i]][seq_c[i]] = 1'b1;
            tick(50);
            release_all();
            tick(30);
            exp_q.push_back(model_key(seq_r[i], seq_c[i]));
        end
        check_seq("sequence", exp_q, got);

        // Two keys on row 1: ignored while both held, rows keep cycling.
        got.delete();
        pressed[1][0] = 1'b1;
        pressed[1][3] = 1'b1;
        seen = 4'h0;
        for (int i = 0; i < 60; i++) begin
            tick(1);
            seen = seen | ~row_n;
        end
        check("rows cycle with two keys", seen, 4'hF);
        check("no emit with two keys", got.size(), 0);
        pressed[1][3] = 1'b0;
        tick(50);
        release_all();
        tick(30);
        exp_q.delete(); exp_q.push_back(model_key(1, 0));
        check_seq("two-key then 4", exp_q, got);

        // Unmapped key holds the row silently; a long hold emits once.
        got.delete();
        pressed[3][4] = 1'b1;
        tick(60);
        check("unmapped holds row3", row_n, 4'b0111);
        tick(940);
        release_all();
        tick(30);
        check("unmapped no emit", got.size(), 0);
        pressed[0][1] = 1'b1;
        tick(1000);
        release_all();
        tick(30);
        exp_q.delete(); exp_q.push_back(model_key(0, 1));
        check_seq("held 1000 clocks", exp_q, got);

        // Reset pulse in the middle of debouncing "5".
        tick(10);
        got.delete();
        wait_row(4'b1110, 40, found);
        check("reach row0 before 5", found, 1);
        pressed[1][1] = 1'b1;
        wait_row(4'b1101, 40, found);
        check("reach row1 for 5", found, 1);
        tick(5);
        rst_b = 1'b0;
        release_all();
        tick(1);
        check("abort row_n", row_n, 4'b1110);
        check("abort keyIn", key_in, 8'h00);
        rst_b = 1'b1;
        tick(1);
        check("restart at row0", row_n, 4'b1110);
        tick(60);
        exp_q.delete();
        check_seq("reset abort", exp_q, got);

        // Random presses, some with a stray second key during the hold.
        got.delete();
        got_f.delete();
        exp_q.delete();
        for (int i = 0; i < 30; i++) begin
            r    = $urandom_range(3, 0);
            c    = $urandom_range(4, 0);
            hold = $urandom_range(120, 45);
            gap  = $urandom_range(50, 25);
            pressed[r][c] = 1'b1;
            if ($urandom_range(3, 0) == 0) begin
                tick(40);
                pressed[$urandom_range(3, 0)][$urandom_range(4, 0)] = 1'b1;
                tick(hold - 40);
            end else begin
                tick(hold);
            end
            release_all();
            tick(gap);
            if (model_key(r, c) != 8'h00) exp_q.push_back(model_key(r, c));
        end
        check_seq("random", exp_q, got);
        check_seq("random fast", exp_q, got_f);

        check("row_n one-hot-low", row_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
